// File: rtl/dmem_port_ctrl_pkg.sv
// dmem_port_ctrl_pkg: state/owner encodings and access size shared by the data-memory port controller
package dmem_port_ctrl_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;
  typedef enum logic {OWN_M = 1'b0, OWN_F = 1'b1} owner_t;
  localparam int WORD_BYTES = 8;
endpackage

// File: rtl/dmem_addr_check.sv
// dmem_addr_check: flags an 8-byte access that would run past the end of RAM, including 64-bit wrap-around
module dmem_addr_check #(
  parameter int MEM_BYTES = 1024
) (
  input  logic [63:0] addr,
  output logic        error
);
  assign error = ({1'b0, addr} + 65'd7) >= 65'(MEM_BYTES);
endmodule

// File: rtl/dmem_port_ctrl.sv
// dmem_port_ctrl: arbitrates the byte-wide data RAM between memory stage and fetch,
// sequencing each 64-bit little-endian access as eight single-byte RAM cycles
module dmem_port_ctrl
  import dmem_port_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m_req_i,
  input  logic              m_we_i,
  input  logic [63:0]       m_addr_i,
  input  logic [63:0]       m_wdata_i,
  output logic [63:0]       m_rdata_o,
  output logic              m_done_o,
  output logic              m_error_o,
  input  logic              f_req_i,
  input  logic [63:0]       f_addr_i,
  output logic [63:0]       f_rdata_o,
  output logic              f_done_o,
  output logic              f_error_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [7:0]        ram_wdata_o,
  input  logic [7:0]        ram_rdata_i
);
  state_t              state, nextState;
  owner_t              owner;
  logic                we;
  logic [ADDR_W-1:0]   addr;
  logic [63:0]         wdata;
  logic [55:0]         result;
  logic [2:0]          cnt;
  logic [63:0]         grantAddr;
  logic                grantErr, grantM, grantF, busy, lastByte, finM, finF;
  logic [63:0]         finalData;

  assign grantM    = state == S_IDLE && m_req_i;
  assign grantF    = state == S_IDLE && !m_req_i && f_req_i;
  assign grantAddr = m_req_i ? m_addr_i : f_addr_i;
  assign busy      = state == S_BUSY;
  assign lastByte  = cnt == 3'(WORD_BYTES - 1);
  assign finM      = busy && lastByte && owner == OWN_M;
  assign finF      = busy && lastByte && owner == OWN_F;
  // The last byte is taken straight from the RAM so the word completes in the same edge
  assign finalData = we ? '0 : {ram_rdata_i, result};

  dmem_addr_check #(.MEM_BYTES(MEM_BYTES)) uChk (.addr(grantAddr), .error(grantErr));

  always_ff @(posedge clk_i)
    if (rst_i) state <= S_IDLE;
    else state <= nextState;

  always_comb
    nextState = state == S_IDLE ? ((m_req_i | f_req_i) ? (grantErr ? S_DONE : S_BUSY) : S_IDLE) :
                state == S_BUSY ? (lastByte ? S_DONE : S_BUSY) : S_IDLE;

  // Write enable is masked by reset so an aborted write leaves the current byte untouched
  always_comb begin
    ram_addr_o  = busy ? addr + ADDR_W'(cnt) : '0;
    ram_we_o    = busy & we & ~rst_i;
    ram_wdata_o = (busy & we) ? wdata[{cnt, 3'b000} +: 8] : '0;
  end

  always_ff @(posedge clk_i)
    if (rst_i) begin
      owner     <= OWN_M;
      we        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      result    <= '0;
      cnt       <= '0;
      m_rdata_o <= '0;
      f_rdata_o <= '0;
      m_done_o  <= 1'b0;
      f_done_o  <= 1'b0;
      m_error_o <= 1'b0;
      f_error_o <= 1'b0;
    end else begin
      m_done_o  <= (grantM & grantErr) | finM;
      f_done_o  <= (grantF & grantErr) | finF;
      m_error_o <= grantM & grantErr;
      f_error_o <= grantF & grantErr;
      if ((grantM & grantErr) | finM) m_rdata_o <= finM ? finalData : '0;
      if ((grantF & grantErr) | finF) f_rdata_o <= finF ? finalData : '0;
      if (grantM | grantF) begin
        owner <= m_req_i ? OWN_M : OWN_F;
        we    <= m_req_i & m_we_i;
        addr  <= grantAddr[ADDR_W-1:0];
        wdata <= m_wdata_i;
        cnt   <= '0;
      end
      if (busy) begin
        result <= {ram_rdata_i, result[55:8]};
        cnt    <= cnt + 3'd1;
      end
    end
endmodule
